des_key_sched_dec: RTL and testbench

//  Iterative DES decryption key schedule: accepts a 64-bit key, streams 16 48-bit

---
 rtl/des_pkg.sv | 51 +++++
 rtl/key_round_step_rev.sv | 23 ++
 rtl/des_key_sched_dec.sv | 119 +++++++++++
 tb/tb_des_key_sched_dec.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES key-schedule constants: PC-1/PC-2 tables, decrypt rotate schedule, FSM encoding.
// Table entries use DES bit numbering (1 = MSB).
package des_pkg;
    localparam int KEY_W  = 64;
    localparam int CD_W   = 56;
    localparam int HALF_W = 28;
    localparam int SK_W   = 48;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam byte unsigned PC1 [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam byte unsigned PC2 [SK_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Right-rotate amount needed to reach the CD of decrypt round r from round r-1
    localparam logic [1:0] RSHIFT_DEC [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] r;
        r = '0;
        for (int i = 0; i < CD_W; i++) begin
            r[CD_W-1-i] = k[KEY_W - int'(PC1[i])];
        end
        return r;
    endfunction

    function automatic logic [SK_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SK_W-1:0] r;
        r = '0;
        for (int i = 0; i < SK_W; i++) begin
            r[SK_W-1-i] = cd[CD_W - int'(PC2[i])];
        end
        return r;
    endfunction
endpackage

// File: rtl/key_round_step_rev.sv
// Purpose: right-rotate each 28-bit half of CD by 0/1/2.
// Latency: combinational. Backpressure: none (pure function).
module key_round_step_rev
    import des_pkg::*;
(
    input  logic [CD_W-1:0] cd_in,
    input  logic [1:0]      amt,
    output logic [CD_W-1:0] cd_out
);
    logic [HALF_W-1:0] c_h, d_h;

    assign c_h = cd_in[CD_W-1:HALF_W];
    assign d_h = cd_in[HALF_W-1:0];

    always_comb begin
        cd_out = cd_in;
        case (amt)
            2'd1:    cd_out = {c_h[0],   c_h[HALF_W-1:1], d_h[0],   d_h[HALF_W-1:1]};
            2'd2:    cd_out = {c_h[1:0], c_h[HALF_W-1:2], d_h[1:0], d_h[HALF_W-1:2]};
            default: cd_out = cd_in;
        endcase
    end
endmodule

// File: rtl/des_key_sched_dec.sv
// Purpose: iterative DES decrypt key schedule, streams K16..K1 (optional KEY_PARITY_CHECK_EN adds parity_err).
// Latency: K16 valid the cycle after key accept, then one subkey per accepted beat.
// Backpressure: subkey held stable until subkey_ready; key_ready low while a stream is in flight.
module des_key_sched_dec
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic [SK_W-1:0]  subkey,
    output logic [3:0]       subkey_round,
    output logic             subkey_valid,
    input  logic             subkey_ready,
    output logic             subkey_last,
`ifdef KEY_PARITY_CHECK_EN
    output logic             parity_err,
`endif
    output logic             busy
);
    generate
        if (NUM_ROUNDS != 16) begin : g_bad_rounds
            $error("des_key_sched_dec: NUM_ROUNDS must be 16");
        end
    endgenerate

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t          state_q, state_d;
    logic [CD_W-1:0] cd_q, cd_rot;
    logic [3:0]      round_q;
    logic [1:0]      rot_amt;
    logic            load, accept, final_beat;

    assign load       = key_valid & key_ready;
    assign accept     = subkey_valid & subkey_ready;
    assign final_beat = (round_q == LAST_ROUND);

    // The last step rotates by one more so CD wraps back to CD0 when the stream ends
    assign rot_amt = final_beat ? 2'd1 : RSHIFT_DEC[round_q + 4'd1];

    key_round_step_rev u_step (
        .cd_in  (cd_q),
        .amt    (rot_amt),
        .cd_out (cd_rot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load)                state_d = ST_RUN;
            ST_RUN:  if (accept & final_beat) state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        key_ready    = 1'b0;
        subkey_valid = 1'b0;
        busy         = 1'b0;
        case (state_q)
            ST_IDLE: key_ready = 1'b1;
            ST_RUN: begin
                subkey_valid = 1'b1;
                busy         = 1'b1;
            end
            default: key_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_q    <= '0;
            round_q <= '0;
        end else if (load) begin
            cd_q    <= pc1(key_in);
            round_q <= '0;
        end else if (accept) begin
            cd_q <= cd_rot;
            if (!final_beat) begin
                round_q <= round_q + 4'd1;
            end
        end
    end

`ifdef KEY_PARITY_CHECK_EN
    logic any_even;

    always_comb begin
        any_even = 1'b0;
        for (int b = 0; b < KEY_W / 8; b++) begin
            any_even = any_even | ~(^key_in[b*8 +: 8]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (load) begin
            parity_err <= any_even;
        end
    end
`endif

    assign subkey       = pc2(cd_q);
    assign subkey_round = round_q;
    assign subkey_last  = subkey_valid & final_beat;
endmodule

// File: tb/tb_des_key_sched_dec.sv
// Bench for des_key_sched_dec: reference model builds the standard encryption schedule
// (left rotations K1..K16) and the scoreboard expects it reversed.
module tb_des_key_sched_dec;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] key_in = '0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_valid;
    logic        subkey_ready = 1'b1;
    logic        subkey_last;
    logic        busy;
`ifdef KEY_PARITY_CHECK_EN
    logic        parity_err;
`endif

    des_key_sched_dec dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .subkey       (subkey),
        .subkey_round (subkey_round),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey_last  (subkey_last),
`ifdef KEY_PARITY_CHECK_EN
        .parity_err   (parity_err),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] sk;
        logic [3:0]  rnd;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          rand_rdy = 1'b0;
    logic [55:0] model_cd0;
    logic [47:0] first_sk, last_sk;

    int PC1_T[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                      63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int PC2_T[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                      41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int LSHIFT[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] rotl28(input logic [27:0] h, input int n);
        logic [27:0] r;
        r = h;
        for (int i = 0; i < n; i++) r = {r[26:0], r[27]};
        return r;
    endfunction

    // Encryption-order schedule K1..K16, queued in decryption order K16..K1
    task automatic model_push(input logic [63:0] k);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] ks[17];
        for (int j = 0; j < 28; j++) begin
            c[27-j] = k[64 - PC1_T[j]];
            d[27-j] = k[64 - PC1_T[28+j]];
        end
        model_cd0 = {c, d};
        for (int r = 1; r <= 16; r++) begin
            c  = rotl28(c, LSHIFT[r-1]);
            d  = rotl28(d, LSHIFT[r-1]);
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[r][47-i] = cd[56 - PC2_T[i]];
        end
        for (int r = 16; r >= 1; r--) begin
            exp_t e;
            e.sk   = ks[r];
            e.rnd  = 4'(16 - r);
            e.last = (r == 1);
            sb.push_back(e);
        end
    endtask

    // Monitor: pops on each handshake, also checks hold-while-stalled
    bit          prev_stall = 1'b0;
    logic [47:0] prev_sk;
    logic [3:0]  prev_rnd;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(subkey_valid), 64'd1);
                check("stall_subkey", 64'(subkey), 64'(prev_sk));
                check("stall_round", 64'(subkey_round), 64'(prev_rnd));
            end
            if (subkey_valid && subkey_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_subkey", 64'(subkey), 64'hx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("subkey", 64'(subkey), 64'(e.sk));
                    check("subkey_round", 64'(subkey_round), 64'(e.rnd));
                    check("subkey_last", 64'(subkey_last), 64'(e.last));
                    if (subkey_round == 4'd0) first_sk = subkey;
                    if (subkey_round == 4'd15) last_sk = subkey;
                end
            end
            prev_stall = subkey_valid && !subkey_ready;
            prev_sk    = subkey;
            prev_rnd   = subkey_round;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            subkey_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_key(input logic [63:0] k);
        int t;
        t = 0;
        while (!key_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!key_ready) begin
            check("key_ready_timeout", 64'(key_ready), 64'd1);
        end else begin
            key_in    = k;
            key_valid = 1'b1;
            model_push(k);
            @(posedge clk); #1;
            key_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || !key_ready) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_key_ready", 64'(key_ready), 64'd1);
        check("rst_subkey_valid", 64'(subkey_valid), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        check("rst_round", 64'(subkey_round), 64'd0);
        check("rst_last", 64'(subkey_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
    endtask

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;

    initial begin
        // 1: reset values
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2: known-answer key, always ready, one-cycle latency
        send_key(KAT_KEY);
        check("lat_valid", 64'(subkey_valid), 64'd1);
        check("lat_round", 64'(subkey_round), 64'd0);
        check("lat_busy", 64'(busy), 64'd1);
        check("lat_key_ready", 64'(key_ready), 64'd0);
        wait_drain();
        check("kat_k16", 64'(first_sk), 64'hCB3D8B0E17F5);
        check("kat_k1", 64'(last_sk), 64'h1B02EFFC7072);

        // 3: same key with random backpressure; CD must wrap back to CD0
        rand_rdy = 1'b1;
        send_key(KAT_KEY);
        wait_drain();
        check("cd_after_stream", 64'(dut.cd_q), 64'h00F0CCAAF556678F);
        check("cd_model", 64'(dut.cd_q), 64'(model_cd0));

        // 4: key offered while busy must be ignored
        send_key(KAT_KEY);
        repeat (3) @(posedge clk);
        #1;
        check("busy_key_ready", 64'(key_ready), 64'd0);
        key_in    = 64'h0123456789ABCDEF;
        key_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        key_valid = 1'b0;
        wait_drain();

        // 5: reset at round 7 aborts; next key restarts cleanly
        rand_rdy = 1'b0;
        send_key({$urandom, $urandom});
        begin
            int t;
            t = 0;
            while (subkey_round != 4'd7 && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            check("reach_round7", 64'(subkey_round), 64'd7);
        end
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_key({$urandom, $urandom});
        check("restart_round", 64'(subkey_round), 64'd0);
        wait_drain();

        // random keys, random backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 8; n++) begin
            send_key({$urandom, $urandom});
            wait_drain();
            check("rand_cd_wrap", 64'(dut.cd_q), 64'(model_cd0));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

`ifdef KEY_PARITY_CHECK_EN
        // 6: parity flag, stream still produced
        send_key(KAT_KEY);
        check("parity_ok", 64'(parity_err), 64'd0);
        wait_drain();
        send_key(64'h123457799BBCDFF1);
        check("parity_bad", 64'(parity_err), 64'd1);
        wait_drain();
        check("parity_held", 64'(parity_err), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
